// File: rtl/mult_booth_32_pkg.sv
// Shared state encoding and sizing for the radix-2 Booth multiplier.
package mult_booth_32_pkg;

    localparam int unsigned W     = 32;
    localparam int unsigned PW    = 2 * W + 1;
    localparam int unsigned ITERS = 32;
    localparam int unsigned CNT_W = 6;

    // Encoding 2'd3 is unused and recovers to ST_IDLE.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mult_booth_32_cla.sv
// 32-bit adder: eight 4-bit groups with group generate/propagate lookahead between groups.
module cla_32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);

    logic [31:0] g;
    logic [31:0] p;

    assign g = a & b;
    assign p = a ^ b;

    always_comb begin : adder
        logic cy;
        logic bc;
        logic gg;
        logic gp;
        sum = '0;
        cy  = cin;
        for (int k = 0; k < 8; k++) begin
            gg = 1'b0;
            gp = 1'b1;
            bc = cy;
            for (int j = 0; j < 4; j++) begin
                sum[4*k+j] = p[4*k+j] ^ bc;
                bc = g[4*k+j] | (p[4*k+j] & bc);
                gg = g[4*k+j] | (p[4*k+j] & gg);
                gp = gp & p[4*k+j];
            end
            // Carry into the next group comes from the group terms, not the ripple.
            cy = gg | (gp & cy);
        end
        cout = cy;
    end

endmodule

// File: rtl/mult_booth_32.sv
// Multicycle signed 32x32 radix-2 Booth multiplier; low 32 bits of the product plus overflow flag.
module mult_booth_32
    import mult_booth_32_pkg::*;
(
    input  logic         clock,
    input  logic         reset,
    input  logic         ctrl_MULT,
    input  logic [W-1:0] data_operandA,
    input  logic [W-1:0] data_operandB,
    output logic [W-1:0] data_result,
    output logic         data_exception,
    output logic         data_resultRDY,
    output logic         busy
);

    state_t           state, state_n;
    logic [CNT_W-1:0] count, count_n;
    logic [PW-1:0]    p, p_n;
    logic [W-1:0]     m, m_n;

    logic [W-1:0]     u;
    logic             do_add;
    logic             do_sub;
    logic [W-1:0]     yeff;
    logic [W-1:0]     cla_sum;
    logic             cla_cout_unused;
    logic [W-1:0]     s;
    logic             ovf;
    logic [PW-1:0]    p_shift;

    // Booth decode on the two low bits of P.
    assign u      = p[PW-1:W+1];
    assign do_add = (p[1:0] == 2'b01);
    assign do_sub = (p[1:0] == 2'b10);
    assign yeff   = do_sub ? ~m : m;

    cla_32 u_cla (
        .a    (u),
        .b    (yeff),
        .cin  (do_sub),
        .sum  (cla_sum),
        .cout (cla_cout_unused)
    );

    // The true 33-bit sign is S[31] flipped on overflow; keeps M = 0x80000000 exact.
    assign s       = (do_add || do_sub) ? cla_sum : u;
    assign ovf     = (do_add || do_sub) && (u[W-1] == yeff[W-1]) && (s[W-1] != u[W-1]);
    assign p_shift = {s[W-1] ^ ovf, s, p[W:1]};

    always_comb begin
        state_n = state;
        count_n = count;
        p_n     = p;
        m_n     = m;
        case (state)
            ST_IDLE: begin
                if (ctrl_MULT) begin
                    state_n = ST_RUN;
                    count_n = '0;
                    m_n     = data_operandA;
                    p_n     = {W'(0), data_operandB, 1'b0};
                end
            end
            ST_RUN: begin
                if (ctrl_MULT) begin
                    count_n = '0;
                    m_n     = data_operandA;
                    p_n     = {W'(0), data_operandB, 1'b0};
                end else begin
                    p_n     = p_shift;
                    count_n = count + CNT_W'(1);
                    if (count == CNT_W'(ITERS - 1)) begin
                        state_n = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (ctrl_MULT) begin
                    state_n = ST_RUN;
                    count_n = '0;
                    m_n     = data_operandA;
                    p_n     = {W'(0), data_operandB, 1'b0};
                end else begin
                    state_n = ST_IDLE;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state          <= ST_IDLE;
            count          <= '0;
            p              <= '0;
            m              <= '0;
            data_result    <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
            busy           <= 1'b0;
        end else begin
            state          <= state_n;
            count          <= count_n;
            p              <= p_n;
            m              <= m_n;
            data_resultRDY <= (state_n == ST_DONE);
            busy           <= (state_n == ST_RUN);
            // Result and overflow load only on the final iteration and hold otherwise.
            if (state_n == ST_DONE) begin
                data_result    <= p_n[W:1];
                data_exception <= ~(p_n[PW-1:W+1] == {W{p_n[W]}});
            end
        end
    end

endmodule
